// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding selects, bubble constants,
// the ID/EX bundle and the register-match helper.
package pipeline_pkg;

  localparam int CTRL_W_DEF = 16;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  // $0 is hard-wired, so a write to it never produces a value
  function automatic logic reg_hit(
    input logic       wr,
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return wr && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic ex_hit,
    input logic mem_hit
  );
    logic [1:0] s;
    s = FWD_RF;
    if (ex_hit)
      s = FWD_MEM;
    else if (mem_hit)
      s = FWD_WB;
    return s;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detection and next-cycle forward selects
// for the instruction currently in ID.
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] mem_dst,
  input  logic       mem_reg_write,
  output logic       load_use,
  output logic [1:0] fwd_a_next,
  output logic [1:0] fwd_b_next
);

  logic ex_wr;
  logic ex_ld;
  logic rs_dep;
  logic rt_dep;

  assign ex_wr = ex_valid & ex_reg_write;
  assign ex_ld = ex_valid & ex_mem_read;

  assign rs_dep = id_uses_rs & reg_hit(ex_ld, ex_dst, id_rs);
  assign rt_dep = id_uses_rt & reg_hit(ex_ld, ex_dst, id_rt);

  assign load_use = id_valid & (rs_dep | rt_dep);

  assign fwd_a_next = fwd_sel(
    reg_hit(ex_wr, ex_dst, id_rs),
    reg_hit(mem_reg_write, mem_dst, id_rs)
  );

  assign fwd_b_next = fwd_sel(
    reg_hit(ex_wr, ex_dst, id_rt),
    reg_hit(mem_reg_write, mem_dst, id_rt)
  );

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// registered forward selects and a saturating stall counter.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        mem_dst,
  input  logic              mem_reg_write,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              id_stall,
  output logic [CNT_W-1:0]  stall_count
);

  id_ex_t            ex_q, ex_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       load_use;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  hazard_unit u_hazard (
    .ex_valid      (ex_q.valid),
    .ex_reg_write  (ex_q.reg_write),
    .ex_mem_read   (ex_q.mem_read),
    .ex_dst        (ex_q.dst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .mem_dst       (mem_dst),
    .mem_reg_write (mem_reg_write),
    .load_use      (load_use),
    .fwd_a_next    (fwd_a_next),
    .fwd_b_next    (fwd_b_next)
  );

  assign id_stall = load_use & ~flush & ~hold;

  always_comb begin
    ex_d   = ID_EX_BUBBLE;
    ctrl_d = CTRL_W'(CTRL_BUBBLE);
    cnt_d  = cnt_q;
    priority case (1'b1)
      flush: begin
      end
      load_use: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        ex_d.valid     = id_valid;
        ex_d.pc        = id_pc;
        ex_d.rs        = id_rs;
        ex_d.rt        = id_rt;
        ex_d.dst       = id_dst;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        ex_d.rs_data   = id_rs_data;
        ex_d.rt_data   = id_rt_data;
        ex_d.imm       = id_imm;
        ex_d.fwd_a     = fwd_a_next;
        ex_d.fwd_b     = fwd_b_next;
        ctrl_d         = id_ctrl;
      end
    endcase
  end

  // hold freezes everything, including the stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= ID_EX_BUBBLE;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else if (!hold) begin
      ex_q   <= ex_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dst       = ex_q.dst;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ctrl_q;
  assign ex_fwd_a     = ex_q.fwd_a;
  assign ex_fwd_b     = ex_q.fwd_b;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction sequences,
// expected EX state queued by the driver and checked by a monitor.
module tb_id_ex_stage;

  localparam int CW = 3;
  localparam logic [1:0] RF  = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] WB  = 2'd2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [31:0]   id_pc = '0;
  logic [4:0]    id_rs = '0;
  logic [4:0]    id_rt = '0;
  logic [4:0]    id_dst = '0;
  logic          id_uses_rs = 1'b0;
  logic          id_uses_rt = 1'b0;
  logic          id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0;
  logic [31:0]   id_rs_data = '0;
  logic [31:0]   id_rt_data = '0;
  logic [31:0]   id_imm = '0;
  logic [15:0]   id_ctrl = '0;
  logic [4:0]    mem_dst = '0;
  logic          mem_reg_write = 1'b0;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic [4:0]    ex_rs;
  logic [4:0]    ex_rt;
  logic [4:0]    ex_dst;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [31:0]   ex_rs_data;
  logic [31:0]   ex_rt_data;
  logic [31:0]   ex_imm;
  logic [15:0]   ex_ctrl;
  logic [1:0]    ex_fwd_a;
  logic [1:0]    ex_fwd_b;
  logic          id_stall;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(16), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .id_stall(id_stall), .stall_count(stall_count)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic          stall;
    logic          valid;
    logic [31:0]   pc;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    dst;
    logic          rw;
    logic          mr;
    logic [31:0]   rsd;
    logic [31:0]   rtd;
    logic [31:0]   imm;
    logic [15:0]   ctrl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e1 = '0;
  exp_t e2 = '0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] n = '0;

  function automatic instr_t R(input logic [4:0] s, t, d);
    instr_t i;
    i = '{v: 1'b1, rs: s, rt: t, dst: d,
          urs: 1'b1, urt: 1'b1, rw: 1'b1, mr: 1'b0};
    return i;
  endfunction

  function automatic instr_t LW(input logic [4:0] b, d);
    instr_t i;
    i = '{v: 1'b1, rs: b, rt: d, dst: d,
          urs: 1'b1, urt: 1'b0, rw: 1'b1, mr: 1'b1};
    return i;
  endfunction

  localparam instr_t NOP = '0;

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(
    input instr_t in, input logic h, f, rst,
    input logic ld, st, input logic [1:0] fa, fb,
    input logic [CW-1:0] cnt
  );
    exp_t e;
    @(negedge clk);
    n++;
    reset        = rst;
    hold         = h;
    flush        = f;
    id_valid     = in.v;
    id_rs        = in.rs;
    id_rt        = in.rt;
    id_dst       = in.dst;
    id_uses_rs   = in.urs;
    id_uses_rt   = in.urt;
    id_reg_write = in.rw;
    id_mem_read  = in.mr;
    id_pc        = in.v ? 32'h0040_0000 + 32'(n) * 4 : '0;
    id_rs_data   = in.v ? 32'hA000_0000 | 32'(n) : '0;
    id_rt_data   = in.v ? 32'hB000_0000 | 32'(n) : '0;
    id_imm       = in.v ? 32'hC000_0000 | 32'(n) : '0;
    id_ctrl      = in.v ? 16'h5A00 | 16'(n) : '0;
    mem_dst       = e2.dst;
    mem_reg_write = e2.rw;
    e = '0;
    if (!rst && h) begin
      e = e1;
    end else if (!rst && ld) begin
      e.valid = in.v;
      e.pc    = id_pc;
      e.rs    = in.rs;
      e.rt    = in.rt;
      e.dst   = in.dst;
      e.rw    = in.rw;
      e.mr    = in.mr;
      e.rsd   = id_rs_data;
      e.rtd   = id_rt_data;
      e.imm   = id_imm;
      e.ctrl  = id_ctrl;
      e.fa    = fa;
      e.fb    = fb;
    end
    e.stall = st;
    e.cnt   = cnt;
    q.push_back(e);
    if (!h) begin
      e2 = e1;
      e1 = e;
    end
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("id_stall", 32'(id_stall), 32'(m.stall));
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rs", 32'(ex_rs), 32'(m.rs));
        chk("ex_rt", 32'(ex_rt), 32'(m.rt));
        chk("ex_dst", 32'(ex_dst), 32'(m.dst));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("ex_rs_data", ex_rs_data, m.rsd);
        chk("ex_rt_data", ex_rt_data, m.rtd);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
        chk("ex_fwd_a", 32'(ex_fwd_a), 32'(m.fa));
        chk("ex_fwd_b", 32'(ex_fwd_b), 32'(m.fb));
        chk("stall_count", 32'(stall_count), 32'(m.cnt));
      end
    end
  end

  initial begin : driver
    logic [CW-1:0] c;
    // reset, then idle
    step(NOP, 0, 0, 1, 0, 0, RF, RF, 0);
    step(NOP, 0, 0, 1, 0, 0, RF, RF, 0);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 0);
    // back-to-back, one gap, two gaps
    step(R(1, 2, 3), 0, 0, 0, 1, 0, RF, RF, 0);
    step(R(3, 5, 4), 0, 0, 0, 1, 0, MEM, RF, 0);
    step(R(1, 2, 3), 0, 0, 0, 1, 0, RF, RF, 0);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 0);
    step(R(3, 5, 4), 0, 0, 0, 1, 0, WB, RF, 0);
    step(R(1, 2, 3), 0, 0, 0, 1, 0, RF, RF, 0);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 0);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 0);
    step(R(3, 5, 4), 0, 0, 0, 1, 0, RF, RF, 0);
    // lw $8 then add $9,$8,$8
    step(LW(29, 8), 0, 0, 0, 1, 0, RF, RF, 0);
    step(R(8, 8, 9), 0, 0, 0, 0, 1, RF, RF, 1);
    step(R(8, 8, 9), 0, 0, 0, 1, 0, WB, WB, 1);
    // $0 is never a dependency
    step(R(1, 2, 0), 0, 0, 0, 1, 0, RF, RF, 1);
    step(R(0, 0, 5), 0, 0, 0, 1, 0, RF, RF, 1);
    step(LW(1, 0), 0, 0, 0, 1, 0, RF, RF, 1);
    step(R(0, 0, 6), 0, 0, 0, 1, 0, RF, RF, 1);
    // same dst in EX and MEM: youngest wins
    step(R(1, 2, 7), 0, 0, 0, 1, 0, RF, RF, 1);
    step(R(1, 2, 7), 0, 0, 0, 1, 0, RF, RF, 1);
    step(R(7, 7, 10), 0, 0, 0, 1, 0, MEM, MEM, 1);
    // flush together with load-use
    step(LW(1, 11), 0, 0, 0, 1, 0, RF, RF, 1);
    step(R(11, 2, 12), 0, 1, 0, 0, 0, RF, RF, 1);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 1);
    // hold during load-use
    step(LW(1, 13), 0, 0, 0, 1, 0, RF, RF, 1);
    for (int i = 0; i < 3; i++)
      step(R(2, 13, 14), 1, 0, 0, 0, 0, RF, RF, 1);
    step(R(2, 13, 14), 0, 0, 0, 0, 1, RF, RF, 2);
    step(R(2, 13, 14), 0, 0, 0, 1, 0, RF, WB, 2);
    // drive the 3-bit counter into saturation
    c = 2;
    for (int i = 0; i < 6; i++) begin
      step(LW(1, 15), 0, 0, 0, 1, 0, RF, RF, c);
      if (c != 3'd7) c = c + 1'b1;
      step(R(15, 0, 16), 0, 0, 0, 0, 1, RF, RF, c);
      step(R(15, 0, 16), 0, 0, 0, 1, 0, WB, RF, c);
    end
    // reset in the middle of a load-use
    step(LW(1, 17), 0, 0, 0, 1, 0, RF, RF, 7);
    step(R(17, 0, 18), 0, 0, 1, 0, 1, RF, RF, 0);
    step(R(17, 0, 18), 0, 0, 0, 1, 0, WB, RF, 0);
    step(NOP, 0, 0, 0, 1, 0, RF, RF, 0);
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
